uart_tx_driver: RTL and testbench

- Memory-mapped UART transmitter peripheral alongside the light, switch and tube drivers in the IO manager; drives the board's UART-to-PC line.
- The CPU writes bytes through the same do/address/data write-strobe interface the other drivers use.
- Bytes are buffered in a small FIFO and serialized as 8N1 frames, LSB first.
- A status word is readable by the CPU for polling.

---
 rtl/uart_tx_driver.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_driver.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// CPU pushes bytes at addr 0 and polls the status word at addr 1.
module uart_tx_driver #(
  parameter int CLOCKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic        iDoUartWrite,
  input  logic [1:0]  iUartAddress,
  input  logic [15:0] iUartDataToWrite,
  input  logic        iDoUartRead,
  output logic [15:0] oUartDataRead,
  output logic        oUartTx,
  output logic        oUartBusy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic                w_line;
  logic [31:0]         w_cnt32;
  logic [3:0]          w_cnt4;
  logic                w_unused;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_push_req = iDoUartWrite && (iUartAddress == 2'd0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = iDoUartWrite && (iUartAddress == 2'd1)
                      && iUartDataToWrite[3];
  assign w_unused   = ^iUartDataToWrite[15:8];

  assign w_cnt32 = 32'(r_count);
  assign w_cnt4  = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];

  assign oUartBusy = (r_state != S_IDLE) || !w_empty;
  assign oUartTx   = r_tx;

  always_comb begin
    oUartDataRead = 16'h0000;
    if (iDoUartRead && (iUartAddress == 2'd1)) begin
      oUartDataRead = {8'h00, w_cnt4, r_ovf, oUartBusy, w_empty, w_full};
    end
  end

  always_comb begin
    w_line = 1'b1;
    unique case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[r_bit];
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge iCpuClock) begin
    if (w_push) begin
      r_mem[r_wptr] <= iUartDataToWrite[7:0];
    end
  end

  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // a set wins over a clear landing in the same cycle
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // line is driven from the previous state, so it lags the FSM by one cycle
  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_line;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_baud == BAUD_MAX) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == BAUD_MAX) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == BAUD_MAX) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Directed bench for uart_tx_driver with a serial-decoding scoreboard.
// Expected bytes are queued on write and popped when a frame is decoded.
module tb_uart_tx_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        rd;
  logic [15:0] rdata;
  logic        tx;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [7:0]  q[$];
  int          st[$];

  uart_tx_driver #(
    .CLOCKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .iCpuClock(clk),
    .iCpuReset(rst),
    .iDoUartWrite(wr),
    .iUartAddress(addr),
    .iUartDataToWrite(wdata),
    .iDoUartRead(rd),
    .oUartDataRead(rdata),
    .oUartTx(tx),
    .oUartBusy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr = 1'b0;
    addr = 2'd0;
    wdata = 16'h0;
  endtask

  task automatic rd_status(output logic [15:0] v);
    rd = 1'b1;
    addr = 2'd1;
    #1;
    v = rdata;
    rd = 1'b0;
    addr = 2'd0;
  endtask

  task automatic drain(input string tag, input int lim);
    int n;
    n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < lim) begin
      tick();
      n++;
    end
    check(tag, 16'(n < lim), 16'd1);
  endtask

  // serial monitor: decodes frames mid-bit and scores them against q
  initial begin : mon
    int ep;
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ep = epoch;
        st.push_back(cyc);
        repeat (2) @(negedge clk);
        if (ep == epoch) check("start_mid", {15'b0, tx}, 16'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        if (ep == epoch) begin
          check("stop_bit", {15'b0, tx}, 16'd1);
          check("frame_expected", 16'(q.size() > 0), 16'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("frame_byte", {8'h0, b}, {8'h0, e});
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] s;
    logic        exp_tx;
    logic [7:0]  byt;
    int          c0;
    int          lows;

    rst = 1'b1;
    wr = 1'b0;
    addr = 2'd0;
    wdata = 16'h0;
    rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("idle_tx", {15'b0, tx}, 16'd1);
    check("idle_busy", {15'b0, busy}, 16'd0);
    rd_status(s);
    check("idle_status", s, 16'h0002);
    rd = 1'b1;
    addr = 2'd0;
    #1;
    check("read_addr0", rdata, 16'h0000);
    rd = 1'b0;

    // single frame, cycle-exact line check
    st.delete();
    q.push_back(8'h55);
    wr_reg(2'd0, 16'h0055);
    c0 = cyc;
    byt = 8'h55;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k >= 2 && k <= 5) exp_tx = 1'b0;
      else if (k >= 6 && k <= 37) exp_tx = byt[(k - 6) / 4];
      else exp_tx = 1'b1;
      check($sformatf("f55_k%0d", k), {15'b0, tx}, {15'b0, exp_tx});
    end
    check("f55_busy_after", {15'b0, busy}, 16'd0);
    drain("f55_drain", 50);
    check("f55_nstart", 16'(st.size()), 16'd1);
    if (st.size() > 0) check("f55_latency", 16'(st[0] - c0), 16'd2);

    // two back-to-back frames
    st.delete();
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    wr_reg(2'd0, 16'h00A5);
    wr_reg(2'd0, 16'h003C);
    drain("b2b_drain", 200);
    check("b2b_nstart", 16'(st.size()), 16'd2);
    if (st.size() > 1) check("b2b_gap", 16'(st[1] - st[0]), 16'd41);

    // overflow, clear, and push in the same cycle as a pop while full
    st.delete();
    for (int i = 1; i <= 5; i++) q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr_reg(2'd0, 16'(i));
    rd_status(s);
    check("ovf_status", s, 16'h004D);
    wr_reg(2'd1, 16'h0008);
    rd_status(s);
    check("ovf_cleared", s, 16'h0045);
    repeat (35) tick();
    rd_status(s);
    check("pre_pop_status", s, 16'h0045);
    q.push_back(8'h07);
    wr_reg(2'd0, 16'h0007);
    rd_status(s);
    check("push_pop_full", s, 16'h0045);
    drain("ovf_drain", 400);
    rd_status(s);
    check("ovf_end_status", s, 16'h0002);
    check("ovf_nstart", 16'(st.size()), 16'd6);

    // reset mid-frame with bytes queued
    st.delete();
    q.push_back(8'hFF);
    q.push_back(8'h11);
    q.push_back(8'h22);
    wr_reg(2'd0, 16'h00FF);
    wr_reg(2'd0, 16'h0011);
    wr_reg(2'd0, 16'h0022);
    repeat (12) tick();
    rst = 1'b1;
    epoch++;
    q.delete();
    tick();
    check("rst_tx", {15'b0, tx}, 16'd1);
    check("rst_busy", {15'b0, busy}, 16'd0);
    rd_status(s);
    check("rst_status", s, 16'h0002);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    wr_reg(2'd2, 16'h0055);
    wr_reg(2'd3, 16'h0055);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("rst_line_quiet", 16'(lows), 16'd0);
    check("rst_nstart", 16'(st.size()), 16'd1);
    rd_status(s);
    check("reserved_ignored", s, 16'h0002);
    check("queue_empty", 16'(q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
